// File: rtl/program_sequencer_stack_if.sv
// rtl/program_sequencer_stack_if.sv - control and address bus of the program sequencer
interface program_sequencer_stack_if #(
    parameter int ADDR_W = 8,
    parameter int JMP_W  = 4,
    parameter int SP_W   = 3
);
    logic              sync_reset;
    logic              hold;
    logic              jmp;
    logic              jmp_nz;
    logic              dont_jmp;
    logic              call;
    logic              ret;
    logic [JMP_W-1:0]  jmp_addr;
    logic [ADDR_W-1:0] pm_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] from_PS;
    logic [SP_W-1:0]   stack_depth;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
        input  pm_addr, pc, from_PS, stack_depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
        output pm_addr, pc, from_PS, stack_depth, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/program_sequencer_stack.sv
// rtl/program_sequencer_stack.sv - fetch-stage program sequencer with hardware return stack
module program_sequencer_stack #(
    parameter int ADDR_W      = 8,
    parameter int JMP_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    program_sequencer_stack_if.slave  bus
);
    typedef logic [ADDR_W-1:0] addr_t;

    addr_t           pc_q, pc_d;
    logic [SP_W-1:0] depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    addr_t           stack_q [STACK_DEPTH];
    addr_t           stack_d [STACK_DEPTH];

    addr_t pc_inc;
    addr_t jmp_target;
    addr_t top;
    logic  empty;
    logic  full;
    logic  branch;

    always_comb begin
        pc_inc     = pc_q + addr_t'(1);
        jmp_target = addr_t'(bus.jmp_addr) << (ADDR_W - JMP_W);
        empty      = (depth_q == '0);
        full       = (depth_q == SP_W'(STACK_DEPTH));
        branch     = bus.jmp || (bus.jmp_nz && !bus.dont_jmp);
        // entry depth_q-1 is the top; leaves 0 when the stack is empty
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == SP_W'(i + 1)) begin
                top = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_d    = pc_inc;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;

        if (bus.sync_reset) begin
            pc_d    = '0;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (bus.hold) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            if (!empty) begin
                pc_d    = top;
                depth_d = depth_q - SP_W'(1);
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (bus.call) begin
            // a call on a full stack still jumps; only the push is dropped
            pc_d = jmp_target;
            if (!full) begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (depth_q == SP_W'(i)) begin
                        stack_d[i] = pc_inc;
                    end
                end
                depth_d = depth_q + SP_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (branch) begin
            pc_d = jmp_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // fetch address is held at 0 for the whole time reset_n is low
    assign bus.pm_addr         = reset_n ? pc_d : '0;
    assign bus.pc              = pc_q;
    assign bus.from_PS         = top;
    assign bus.stack_depth     = depth_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// tb/tb_program_sequencer_stack.sv - self-checking bench for program_sequencer_stack
module tb_program_sequencer_stack;
    localparam int ADDR_W      = 8;
    localparam int JMP_W       = 4;
    localparam int STACK_DEPTH = 4;
    localparam int SP_W        = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    program_sequencer_stack_if #(.ADDR_W(ADDR_W), .JMP_W(JMP_W), .SP_W(SP_W)) bus ();

    program_sequencer_stack #(
        .ADDR_W(ADDR_W), .JMP_W(JMP_W), .STACK_DEPTH(STACK_DEPTH), .SP_W(SP_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    bit         m_ovf;
    bit         m_unf;

    function automatic logic [7:0] target();
        return {bus.jmp_addr, 4'h0};
    endfunction

    function automatic logic [7:0] exp_pm();
        if (bus.sync_reset) return 8'h00;
        if (bus.hold) return m_pc;
        if (bus.ret) return (m_stk.size() > 0) ? m_stk[$] : m_pc + 8'd1;
        if (bus.call || bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) return target();
        return m_pc + 8'd1;
    endfunction

    function automatic logic [7:0] exp_top();
        return (m_stk.size() > 0) ? m_stk[$] : 8'h00;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_update();
        logic [7:0] nxt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        nxt = exp_pm();
        if (bus.sync_reset) begin
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!bus.hold) begin
            if (bus.ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1;
            end else if (bus.call) begin
                if (m_stk.size() < STACK_DEPTH) m_stk.push_back(m_pc + 8'd1);
                else m_ovf = 1;
            end
        end
        m_pc = nxt;
    endtask

    task automatic idle();
        bus.sync_reset = 0; bus.hold = 0; bus.jmp = 0; bus.jmp_nz = 0;
        bus.dont_jmp = 0; bus.call = 0; bus.ret = 0; bus.jmp_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic goto_pc(input logic [7:0] a);
        idle();
        bus.jmp = 1; bus.jmp_addr = a[7:4];
        tick();
        idle();
        repeat (int'(a[3:0])) tick();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        model_reset();
        @(negedge clk); #1;
        n_cmp++; if (bus.pm_addr !== 8'h00) begin n_err++; $display("FAIL reset_pm actual=%h required=00", bus.pm_addr); end
        n_cmp++; if (bus.pc !== 8'h00) begin n_err++; $display("FAIL reset_pc actual=%h required=00", bus.pc); end
        @(negedge clk);
        reset_n = 1; #1;
        n_cmp++; if (bus.pm_addr !== 8'h01) begin n_err++; $display("FAIL release_pm1 actual=%h required=01", bus.pm_addr); end
        tick(); #1;
        n_cmp++; if (bus.pm_addr !== 8'h02) begin n_err++; $display("FAIL release_pm2 actual=%h required=02", bus.pm_addr); end
        // build pc 0x37 with two entries pushed, then reset asynchronously
        bus.call = 1; bus.jmp_addr = 4'h3;
        tick(); tick();
        idle();
        repeat (7) tick();
        #1;
        n_cmp++; if (bus.pc !== 8'h37 || bus.stack_depth !== 3'd2) begin n_err++; $display("FAIL midrun_setup actual=%h/%0d required=37/2", bus.pc, bus.stack_depth); end
        #1 reset_n = 0;
        model_reset();
        #1;
        n_cmp++; if ({bus.pc, bus.pm_addr, bus.stack_depth, bus.from_PS} !== {8'h00, 8'h00, 3'd0, 8'h00}) begin
            n_err++; $display("FAIL async_reset actual pc=%h pm=%h depth=%0d tos=%h required all 0", bus.pc, bus.pm_addr, bus.stack_depth, bus.from_PS);
        end
        @(negedge clk);
        reset_n = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++; if (bus.pm_addr !== 8'(k)) begin n_err++; $display("FAIL post_reset_step%0d actual=%h required=%h", k, bus.pm_addr, 8'(k)); end
            tick();
        end
    endtask

    task automatic test_wrap();
        goto_pc(8'hFE);
        #1;
        n_cmp++; if (bus.pm_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_ff actual=%h required=ff", bus.pm_addr); end
        tick(); #1;
        n_cmp++; if (bus.pm_addr !== 8'h00) begin n_err++; $display("FAIL wrap_00 actual=%h required=00", bus.pm_addr); end
        tick(); #1;
        n_cmp++; if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin
            n_err++; $display("FAIL wrap_flags actual=%b%b required=00", bus.stack_overflow, bus.stack_underflow);
        end
    endtask

    task automatic test_jumps();
        idle();
        bus.jmp = 1; bus.jmp_addr = 4'hA; #1;
        n_cmp++; if (bus.pm_addr !== 8'hA0) begin n_err++; $display("FAIL jmp actual=%h required=a0", bus.pm_addr); end
        tick();
        goto_pc(8'h10);
        bus.jmp_nz = 1; bus.dont_jmp = 1; bus.jmp_addr = 4'hA; #1;
        n_cmp++; if (bus.pm_addr !== 8'h11) begin n_err++; $display("FAIL jmp_nz_suppressed actual=%h required=11", bus.pm_addr); end
        bus.dont_jmp = 0; #1;
        n_cmp++; if (bus.pm_addr !== 8'hA0) begin n_err++; $display("FAIL jmp_nz_taken actual=%h required=a0", bus.pm_addr); end
        tick();
    endtask

    task automatic test_call_ret();
        goto_pc(8'h05);
        bus.call = 1; bus.jmp_addr = 4'h3; #1;
        n_cmp++; if (bus.pm_addr !== 8'h30) begin n_err++; $display("FAIL call1 actual=%h required=30", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.from_PS !== 8'h06 || bus.stack_depth !== 3'd1) begin n_err++; $display("FAIL call1_push actual=%h/%0d required=06/1", bus.from_PS, bus.stack_depth); end
        tick();
        bus.call = 1; bus.jmp_addr = 4'h5; #1;
        n_cmp++; if (bus.pm_addr !== 8'h50) begin n_err++; $display("FAIL call2 actual=%h required=50", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_depth !== 3'd2) begin n_err++; $display("FAIL call2_depth actual=%0d required=2", bus.stack_depth); end
        bus.ret = 1; #1;
        n_cmp++; if (bus.pm_addr !== 8'h32) begin n_err++; $display("FAIL ret1 actual=%h required=32", bus.pm_addr); end
        tick(); #1;
        n_cmp++; if (bus.pm_addr !== 8'h06) begin n_err++; $display("FAIL ret2 actual=%h required=06", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_depth !== 3'd0 || bus.from_PS !== 8'h00) begin n_err++; $display("FAIL ret_empty actual=%0d/%h required=0/00", bus.stack_depth, bus.from_PS); end
    endtask

    task automatic test_overflow_underflow();
        idle(); bus.sync_reset = 1; tick(); idle();
        for (int k = 0; k < 5; k++) begin
            bus.call = 1; bus.jmp_addr = 4'(k + 1); #1;
            n_cmp++; if (bus.pm_addr !== {4'(k + 1), 4'h0}) begin n_err++; $display("FAIL ovf_call%0d actual=%h required=%h", k, bus.pm_addr, {4'(k + 1), 4'h0}); end
            tick();
        end
        idle(); #1;
        n_cmp++; if ({bus.stack_depth, bus.stack_overflow, bus.from_PS} !== {3'd4, 1'b1, 8'h31}) begin
            n_err++; $display("FAIL ovf_state actual depth=%0d ovf=%b tos=%h required 4/1/31", bus.stack_depth, bus.stack_overflow, bus.from_PS);
        end
        for (int k = 3; k >= 0; k--) begin
            bus.ret = 1; #1;
            n_cmp++; if (bus.pm_addr !== {4'(k), 4'h1}) begin n_err++; $display("FAIL ovf_pop%0d actual=%h required=%h", k, bus.pm_addr, {4'(k), 4'h1}); end
            tick();
        end
        goto_pc(8'h20);
        bus.ret = 1; #1;
        n_cmp++; if (bus.pm_addr !== 8'h21) begin n_err++; $display("FAIL unf_ret actual=%h required=21", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_underflow !== 1'b1 || bus.stack_overflow !== 1'b1) begin n_err++; $display("FAIL sticky_flags actual=%b%b required=11", bus.stack_overflow, bus.stack_underflow); end
        bus.sync_reset = 1; #1;
        n_cmp++; if (bus.pm_addr !== 8'h00) begin n_err++; $display("FAIL sync_pm actual=%h required=00", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if ({bus.stack_overflow, bus.stack_underflow, bus.stack_depth} !== 5'b0) begin
            n_err++; $display("FAIL sync_clear actual=%b%b/%0d required=00/0", bus.stack_overflow, bus.stack_underflow, bus.stack_depth);
        end
    endtask

    task automatic test_priority();
        goto_pc(8'h44);
        bus.hold = 1; bus.call = 1; bus.jmp_addr = 4'h9; #1;
        n_cmp++; if (bus.pm_addr !== 8'h44) begin n_err++; $display("FAIL hold_call actual=%h required=44", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_depth !== 3'd0 || bus.pc !== 8'h44) begin n_err++; $display("FAIL hold_nopush actual=%0d/%h required=0/44", bus.stack_depth, bus.pc); end
        goto_pc(8'h11);
        bus.call = 1; bus.jmp_addr = 4'h7; tick();
        bus.ret = 1; #1;
        n_cmp++; if (bus.pm_addr !== 8'h12) begin n_err++; $display("FAIL call_ret actual=%h required=12", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_depth !== 3'd0) begin n_err++; $display("FAIL call_ret_depth actual=%0d required=0", bus.stack_depth); end
        bus.jmp = 1; bus.call = 1; bus.jmp_addr = 4'hC; #1;
        n_cmp++; if (bus.pm_addr !== 8'hC0) begin n_err++; $display("FAIL jmp_call actual=%h required=c0", bus.pm_addr); end
        tick(); idle(); #1;
        n_cmp++; if (bus.stack_depth !== 3'd1 || bus.from_PS !== 8'h13) begin n_err++; $display("FAIL jmp_call_push actual=%0d/%h required=1/13", bus.stack_depth, bus.from_PS); end
        bus.sync_reset = 1; bus.jmp = 1; bus.jmp_addr = 4'hB; #1;
        n_cmp++; if (bus.pm_addr !== 8'h00) begin n_err++; $display("FAIL sync_jmp actual=%h required=00", bus.pm_addr); end
        tick(); idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            idle();
            bus.sync_reset = ($urandom_range(0, 99) < 2);
            bus.hold       = ($urandom_range(0, 7) == 0);
            bus.ret        = ($urandom_range(0, 4) == 0);
            bus.call       = ($urandom_range(0, 3) == 0);
            bus.jmp        = ($urandom_range(0, 9) == 0);
            bus.jmp_nz     = ($urandom_range(0, 5) == 0);
            bus.dont_jmp   = 1'($urandom);
            bus.jmp_addr   = 4'($urandom);
            #1;
            n_cmp++;
            if ({bus.pm_addr, bus.pc, bus.from_PS, bus.stack_depth, bus.stack_overflow, bus.stack_underflow} !==
                {exp_pm(), m_pc, exp_top(), 3'(m_stk.size()), m_ovf, m_unf}) begin
                n_err++;
                $display("FAIL random_%0d actual pm=%h pc=%h tos=%h d=%0d o=%b u=%b required pm=%h pc=%h tos=%h d=%0d o=%b u=%b",
                         n, bus.pm_addr, bus.pc, bus.from_PS, bus.stack_depth, bus.stack_overflow, bus.stack_underflow,
                         exp_pm(), m_pc, exp_top(), m_stk.size(), m_ovf, m_unf);
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_jumps();
        test_call_ret();
        test_overflow_underflow();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/program_sequencer_stack.md
Name: program_sequencer_stack

Overview:
- Parametrised program sequencer for the microcontroller fetch stage.
- Each cycle it produces the next program-memory address. Supported flow: sequential increment, unconditional jump, conditional jump, subroutine call and return, and hold (stall).
- Adds a hardware return-address stack with sticky overflow and underflow flags.
- Exposes top-of-stack to the datapath through from_PS.

Parameters:
- ADDR_W, 8: width of pc, pm_addr, from_PS and stack entries.
- JMP_W, 4: width of jmp_addr. The target is {jmp_addr, (ADDR_W-JMP_W) zeros}. Requires JMP_W <= ADDR_W.
- STACK_DEPTH, 4: number of return-address entries. Must be >= 1.
- SP_W, 3: width of stack_depth. Must hold the value STACK_DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous restart to address 0
- hold  in  1  stall: re-present the current pc
- jmp  in  1  unconditional jump
- jmp_nz  in  1  conditional jump
- dont_jmp  in  1  condition flag (zero); suppresses jmp_nz
- call  in  1  push return address and jump
- ret  in  1  pop return address and jump to it
- jmp_addr  in  JMP_W  jump/call target MSBs
- pm_addr  out  ADDR_W  combinational next fetch address
- pc  out  ADDR_W  registered current address
- from_PS  out  ADDR_W  top-of-stack value; 0 when empty
- stack_depth  out  SP_W  number of valid entries
- stack_overflow  out  1  sticky: call attempted while full
- stack_underflow  out  1  sticky: ret attempted while empty

Behaviour:
- Register update: pc <= pm_addr on every rising clk. pc therefore lags pm_addr by exactly one cycle.
- reset_n low (asynchronous):
  - pc = 0, stack_depth = 0, both flags = 0, all stack entries = 0.
  - pm_addr is forced to 0 combinationally while reset_n is low.
  - After reset_n deasserts, pm_addr = 1 in the first cycle, provided no control input is active.
- pm_addr selection, highest priority first:
  1. sync_reset: 0. Next edge sets stack_depth = 0 and clears both flags. Stack contents are don't-care.
  2. hold: pc. Stack and flags unchanged.
  3. ret: if stack_depth > 0, top entry, and the next edge decrements stack_depth. If empty, pc+1, and the next edge sets stack_underflow.
  4. call: the jmp target. If not full, the next edge pushes pc+1 and increments stack_depth. If full, the jump is still taken, nothing is pushed, the stack is unchanged, and stack_overflow is set.
  5. jmp: the jmp target.
  6. jmp_nz && !dont_jmp: the jmp target.
  7. Otherwise: pc+1.
- Simultaneous events resolve strictly by the priority list above. Examples:
  - call+ret: ret acts, no push.
  - jmp+call: call acts (push occurs).
  - hold with anything below it: hold wins, no stack change.
- Arithmetic: pc+1 is computed modulo 2^ADDR_W. 2^ADDR_W-1 wraps to 0, with no flag. A pushed pc+1 wraps the same way.
- from_PS: combinational top entry when stack_depth > 0, else 0. It reflects the registered stack state and updates the cycle after a push or pop.
- Flags are cleared only by reset_n or sync_reset.
- Stack is LIFO. Entries above stack_depth are don't-care.

Test Plan:
- reset_n low mid-run with pc = 8'h37 and stack_depth = 2 -> pc = 0, pm_addr = 0, depth 0 immediately, without waiting for a clk edge. After release, pm_addr steps 1, 2, 3 on successive cycles.
- Sequential wrap: free-run from pc = 8'hFE -> pm_addr FF, then 00. No flags set.
- Jumps: jmp with jmp_addr = 4'hA -> pm_addr = 8'hA0. jmp_nz with dont_jmp = 1 at pc = 8'h10 -> pm_addr = 8'h11. jmp_nz with dont_jmp = 0 -> 8'hA0.
- Nested call/ret:
  - call 4'h3 at pc 8'h05 -> pm_addr = 8'h30. Next cycle from_PS = 8'h06, depth 1.
  - call 4'h5 at pc 8'h31 -> pm_addr = 8'h50, depth 2.
  - ret -> pm_addr = 8'h32. Next ret -> pm_addr = 8'h06, depth 0, from_PS = 0.
- Overflow/underflow:
  - 5 consecutive calls (STACK_DEPTH = 4) -> 5th still jumps, depth stays 4, stack_overflow = 1, stack contents unchanged.
  - ret on empty stack at pc 8'h20 -> pm_addr = 8'h21, stack_underflow = 1.
  - sync_reset clears both flags and depth, and pm_addr = 0.
- Priority/hold:
  - hold+call at pc 8'h44 -> pm_addr = 8'h44, no push.
  - call+ret with depth 1 (top 8'h12) -> pm_addr = 8'h12, depth 0.
  - sync_reset+jmp -> pm_addr = 0.
